// File: rtl/pattern_note_sequencer_pkg.sv
// Note codes and the semitone base-increment table shared by the voice
// channels. Code 0 is a rest; code n>0 is semitone n-1 counted up from C2.
package pattern_note_sequencer_pkg;

  localparam int NOTE_W = 6;

  localparam logic [NOTE_W-1:0] NOTE_RST = 6'd0;
  localparam logic [NOTE_W-1:0] NOTE_C2  = 6'd1;
  localparam logic [NOTE_W-1:0] NOTE_C3  = 6'd13;
  localparam logic [NOTE_W-1:0] NOTE_C4  = 6'd25;
  localparam logic [NOTE_W-1:0] NOTE_E4  = 6'd29;
  localparam logic [NOTE_W-1:0] NOTE_G4  = 6'd32;
  localparam logic [NOTE_W-1:0] NOTE_A4  = 6'd34;
  localparam logic [NOTE_W-1:0] NOTE_C5  = 6'd37;

  // 32-bit phase increments for the C2 octave at a 48 kHz sample rate
  function automatic logic [31:0] note_base(input logic [3:0] semi);
    logic [31:0] inc;
    case (semi)
      4'd0:    inc = 32'd5852430;
      4'd1:    inc = 32'd6200500;
      4'd2:    inc = 32'd6569152;
      4'd3:    inc = 32'd6959817;
      4'd4:    inc = 32'd7373653;
      4'd5:    inc = 32'd7812098;
      4'd6:    inc = 32'd8276669;
      4'd7:    inc = 32'd8768801;
      4'd8:    inc = 32'd9290193;
      4'd9:    inc = 32'd9842633;
      4'd10:   inc = 32'd10427915;
      4'd11:   inc = 32'd11048000;
      default: inc = 32'd0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/note_envelope.sv
// Hold/decay amplitude generator: load jumps to level, then holds for a
// number of ticks and decays linearly, saturating at zero.
module note_envelope #(
  parameter int ENV_W  = 9,
  parameter int HOLD_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tick_stb,
  input  logic              i_load,
  input  logic [ENV_W-1:0]  i_level,
  input  logic [HOLD_W-1:0] i_hold,
  input  logic [ENV_W-1:0]  i_decay,
  output logic [ENV_W-1:0]  o_env
);

  logic [ENV_W-1:0]  env_q,  env_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  always_comb begin
    env_d  = env_q;
    hold_d = hold_q;
    // load outranks a coincident tick so a fresh note always starts at level
    if (i_load) begin
      env_d  = i_level;
      hold_d = '0;
    end else if (i_tick_stb) begin
      if (hold_q < i_hold)        hold_d = hold_q + 1'b1;
      else if (env_q > i_decay)   env_d  = env_q - i_decay;
      else                        env_d  = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      env_q  <= '0;
      hold_q <= '0;
    end else begin
      env_q  <= env_d;
      hold_q <= hold_d;
    end
  end

  assign o_env = env_q;

endmodule

// File: rtl/note_table.sv
// Converts a note code to the phase-accumulator increment; rests give 0.
module note_table
  import pattern_note_sequencer_pkg::*;
(
  input  logic [NOTE_W-1:0] i_note,
  output logic [31:0]       o_phase_delta
);

  logic [NOTE_W-1:0] step;
  logic [3:0]        semi;
  logic [2:0]        oct;

  always_comb begin
    step = i_note - 6'd1;
    semi = 4'(step % 6'd12);
    oct  = 3'(step / 6'd12);
    if (i_note == NOTE_RST) o_phase_delta = 32'd0;
    else                    o_phase_delta = note_base(semi) << oct;
  end

endmodule

// File: rtl/pattern_note_sequencer.sv
// Programmable one-voice note sequencer: pattern RAM, one-shot/loop playback
// and a per-note hold/decay envelope feeding the phase accumulator and mixer.
module pattern_note_sequencer
  import pattern_note_sequencer_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int LEN_W  = 5,
  parameter  int ENV_W  = 9,
  parameter  int HOLD_W = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tick_stb,
  input  logic              i_note_stb,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_loop,
  input  logic [AW-1:0]     i_last,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [NOTE_W-1:0] i_wr_note,
  input  logic [LEN_W-1:0]  i_wr_len,
  input  logic [ENV_W-1:0]  i_env_level,
  input  logic [HOLD_W-1:0] i_env_hold,
  input  logic [ENV_W-1:0]  i_env_decay,
  output logic [31:0]       o_phase_delta,
  output logic [NOTE_W-1:0] o_note,
  output logic              o_new_note,
  output logic [AW-1:0]     o_index,
  output logic [ENV_W-1:0]  o_envelope,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PLAY = 1'b1;

  logic [0:0]       state_q,    state_d;
  logic [AW-1:0]    index_q,    index_d;
  logic [LEN_W-1:0] dur_q,      dur_d;
  logic             new_note_q, new_note_d;
  logic             done_q,     done_d;

  logic [NOTE_W-1:0] note_mem [DEPTH];
  logic [LEN_W-1:0]  len_mem  [DEPTH];
  logic [NOTE_W-1:0] cur_note;
  logic [LEN_W-1:0]  cur_len;
  logic [ENV_W-1:0]  env;

  // Pattern RAM is intentionally unreset; reads are combinational at index
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      note_mem[i_wr_addr] <= i_wr_note;
      len_mem[i_wr_addr]  <= i_wr_len;
    end
  end

  assign cur_note = note_mem[index_q];
  assign cur_len  = len_mem[index_q];

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    dur_d      = dur_q;
    new_note_d = 1'b0;
    done_d     = 1'b0;
    if (i_stop) begin
      state_d = S_IDLE;
    end else if (i_start) begin
      state_d    = S_PLAY;
      index_d    = '0;
      dur_d      = '0;
      new_note_d = 1'b1;
    end else if (state_q == S_PLAY && i_note_stb) begin
      if (dur_q == cur_len) begin
        dur_d = '0;
        if (index_q == i_last) begin
          if (i_loop) begin
            index_d    = '0;
            new_note_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          // a lowered i_last below index lets this wrap mod DEPTH
          index_d    = index_q + 1'b1;
          new_note_d = 1'b1;
        end
      end else begin
        dur_d = dur_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      dur_q      <= '0;
      new_note_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      dur_q      <= dur_d;
      new_note_q <= new_note_d;
      done_q     <= done_d;
    end
  end

  note_envelope #(
    .ENV_W  (ENV_W),
    .HOLD_W (HOLD_W)
  ) u_env (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_tick_stb (i_tick_stb),
    .i_load     (new_note_q),
    .i_level    (i_env_level),
    .i_hold     (i_env_hold),
    .i_decay    (i_env_decay),
    .o_env      (env)
  );

  note_table u_table (
    .i_note        (o_note),
    .o_phase_delta (o_phase_delta)
  );

  assign o_busy     = (state_q == S_PLAY);
  assign o_note     = o_busy ? cur_note : NOTE_RST;
  assign o_envelope = (o_busy && o_note != NOTE_RST) ? env : '0;
  assign o_new_note = new_note_q;
  assign o_done     = done_q;
  assign o_index    = index_q;

endmodule

// File: tb/tb_pattern_note_sequencer.sv
// Directed bench for pattern_note_sequencer: playback modes, envelope shape,
// command priority, async reset and live pattern edits.
module tb_pattern_note_sequencer;
  import pattern_note_sequencer_pkg::*;

  logic        i_clk, i_rst, i_tick_stb, i_note_stb, i_start, i_stop, i_loop;
  logic [3:0]  i_last, i_wr_addr, i_env_hold;
  logic        i_wr_en;
  logic [5:0]  i_wr_note;
  logic [4:0]  i_wr_len;
  logic [8:0]  i_env_level, i_env_decay;
  logic [31:0] o_phase_delta;
  logic [5:0]  o_note;
  logic        o_new_note, o_busy, o_done;
  logic [3:0]  o_index;
  logic [8:0]  o_envelope;

  int npass = 0;
  int ntotal = 0;

  localparam logic [31:0] PD_C4 = 32'd23409720;
  localparam logic [31:0] PD_A4 = 32'd39370532;

  pattern_note_sequencer #(.DEPTH(16), .LEN_W(5), .ENV_W(9), .HOLD_W(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_tick_stb(i_tick_stb), .i_note_stb(i_note_stb),
    .i_start(i_start), .i_stop(i_stop), .i_loop(i_loop), .i_last(i_last),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_note(i_wr_note), .i_wr_len(i_wr_len),
    .i_env_level(i_env_level), .i_env_hold(i_env_hold), .i_env_decay(i_env_decay),
    .o_phase_delta(o_phase_delta), .o_note(o_note), .o_new_note(o_new_note),
    .o_index(o_index), .o_envelope(o_envelope), .o_busy(o_busy), .o_done(o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [5:0] n, input logic [4:0] l);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_note = n; i_wr_len = l;
    step();
    i_wr_en = 1'b0;
  endtask

  task automatic note_pulse();
    i_note_stb = 1'b1; step(); i_note_stb = 1'b0;
  endtask

  task automatic tick_pulse();
    i_tick_stb = 1'b1; step(); i_tick_stb = 1'b0;
  endtask

  task automatic start_play();
    i_start = 1'b1; step(); i_start = 1'b0;
  endtask

  task automatic stop_play();
    i_stop = 1'b1; step(); i_stop = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) step();
    ntotal++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %0d want 0", o_busy); else npass++;
    ntotal++; if (o_new_note !== 1'b0) $display("FAIL reset_new_note: got %0d want 0", o_new_note); else npass++;
    ntotal++; if (o_done !== 1'b0) $display("FAIL reset_done: got %0d want 0", o_done); else npass++;
    ntotal++; if (o_index !== 4'd0) $display("FAIL reset_index: got %0d want 0", o_index); else npass++;
    ntotal++; if (o_note !== NOTE_RST) $display("FAIL reset_note: got %0d want %0d", o_note, NOTE_RST); else npass++;
    ntotal++; if (o_envelope !== 9'd0) $display("FAIL reset_env: got %0d want 0", o_envelope); else npass++;
    i_rst = 1'b0;
    step();
  endtask

  task automatic test_oneshot();
    int exp_idx [6] = '{1, 1, 2, 3, 3, 3};
    int exp_nn  [6] = '{1, 0, 1, 1, 0, 0};
    int nn_cnt;
    wr(4'd0, NOTE_C4, 5'd0);
    wr(4'd1, NOTE_E4, 5'd1);
    wr(4'd2, NOTE_G4, 5'd0);
    wr(4'd3, NOTE_A4, 5'd2);
    i_last = 4'd3; i_loop = 1'b0;
    start_play();
    ntotal++; if (o_busy !== 1'b1) $display("FAIL start_busy: got %0d want 1", o_busy); else npass++;
    ntotal++; if (o_note !== NOTE_C4) $display("FAIL start_note: got %0d want %0d", o_note, NOTE_C4); else npass++;
    ntotal++; if (o_phase_delta !== PD_C4) $display("FAIL start_phase: got %0d want %0d", o_phase_delta, PD_C4); else npass++;
    nn_cnt = int'(o_new_note);
    step();
    for (int k = 0; k < 6; k++) begin
      note_pulse();
      nn_cnt += int'(o_new_note);
      ntotal++; if (o_index !== 4'(exp_idx[k])) $display("FAIL oneshot_index[%0d]: got %0d want %0d", k, o_index, exp_idx[k]); else npass++;
      ntotal++; if (o_new_note !== 1'(exp_nn[k])) $display("FAIL oneshot_new_note[%0d]: got %0d want %0d", k, o_new_note, exp_nn[k]); else npass++;
      step();
    end
    ntotal++; if (o_done !== 1'b0) $display("FAIL oneshot_early_done: got %0d want 0", o_done); else npass++;
    note_pulse();
    nn_cnt += int'(o_new_note);
    ntotal++; if (o_done !== 1'b1) $display("FAIL oneshot_done: got %0d want 1", o_done); else npass++;
    ntotal++; if (o_busy !== 1'b0) $display("FAIL oneshot_busy: got %0d want 0", o_busy); else npass++;
    ntotal++; if (o_note !== NOTE_RST) $display("FAIL oneshot_note_idle: got %0d want %0d", o_note, NOTE_RST); else npass++;
    ntotal++; if (o_envelope !== 9'd0) $display("FAIL oneshot_env_idle: got %0d want 0", o_envelope); else npass++;
    ntotal++; if (nn_cnt !== 4) $display("FAIL oneshot_new_note_count: got %0d want 4", nn_cnt); else npass++;
    step();
    ntotal++; if (o_done !== 1'b0) $display("FAIL oneshot_done_pulse: got %0d want 0", o_done); else npass++;
  endtask

  task automatic test_loop();
    int seq [14] = '{0, 1, 1, 2, 3, 3, 3, 0, 1, 1, 2, 3, 3, 3};
    int done_seen = 0;
    i_loop = 1'b1;
    start_play();
    for (int k = 0; k < 14; k++) begin
      ntotal++; if (o_index !== 4'(seq[k])) $display("FAIL loop_index[%0d]: got %0d want %0d", k, o_index, seq[k]); else npass++;
      note_pulse();
      done_seen += int'(o_done);
    end
    ntotal++; if (done_seen !== 0) $display("FAIL loop_done: got %0d pulses want 0", done_seen); else npass++;
    ntotal++; if (o_busy !== 1'b1 || o_index !== 4'd0) $display("FAIL loop_wrap: got busy %0d index %0d want 1 0", o_busy, o_index); else npass++;
    stop_play();
  endtask

  task automatic test_envelope();
    int exp1 [3] = '{14, 14, 9};
    int exp2 [6] = '{14, 14, 9, 4, 0, 0};
    i_env_level = 9'd14; i_env_hold = 4'd2; i_env_decay = 9'd5; i_loop = 1'b1;
    start_play();
    step();
    ntotal++; if (o_envelope !== 9'd14) $display("FAIL env_attack: got %0d want 14", o_envelope); else npass++;
    for (int k = 0; k < 3; k++) begin
      tick_pulse();
      ntotal++; if (o_envelope !== 9'(exp1[k])) $display("FAIL env_tick_a[%0d]: got %0d want %0d", k, o_envelope, exp1[k]); else npass++;
    end
    note_pulse();
    ntotal++; if (o_new_note !== 1'b1 || o_envelope !== 9'd9) $display("FAIL env_pre_reload: got nn %0d env %0d want 1 9", o_new_note, o_envelope); else npass++;
    step();
    ntotal++; if (o_envelope !== 9'd14) $display("FAIL env_reload: got %0d want 14", o_envelope); else npass++;
    for (int k = 0; k < 6; k++) begin
      tick_pulse();
      ntotal++; if (o_envelope !== 9'(exp2[k])) $display("FAIL env_tick_b[%0d]: got %0d want %0d", k, o_envelope, exp2[k]); else npass++;
    end
    // index 1 has len 1: second strobe advances and raises o_new_note
    note_pulse();
    note_pulse();
    ntotal++; if (o_new_note !== 1'b1) $display("FAIL env_coinc_nn: got %0d want 1", o_new_note); else npass++;
    tick_pulse();
    ntotal++; if (o_envelope !== 9'd14) $display("FAIL env_load_wins: got %0d want 14", o_envelope); else npass++;
    tick_pulse();
    ntotal++; if (o_envelope !== 9'd14) $display("FAIL env_hold_restart: got %0d want 14", o_envelope); else npass++;
    stop_play();
  endtask

  task automatic test_stop_start();
    i_loop = 1'b0;
    start_play();
    note_pulse();
    i_start = 1'b1; i_stop = 1'b1;
    step();
    i_start = 1'b0; i_stop = 1'b0;
    ntotal++; if (o_busy !== 1'b0 || o_done !== 1'b0) $display("FAIL stop_beats_start: got busy %0d done %0d want 0 0", o_busy, o_done); else npass++;
    ntotal++; if (o_note !== NOTE_RST) $display("FAIL stop_note: got %0d want %0d", o_note, NOTE_RST); else npass++;
  endtask

  task automatic test_restart();
    start_play();
    repeat (3) note_pulse();
    ntotal++; if (o_index !== 4'd2) $display("FAIL restart_pre_index: got %0d want 2", o_index); else npass++;
    start_play();
    ntotal++; if (o_index !== 4'd0 || o_new_note !== 1'b1 || o_busy !== 1'b1) $display("FAIL restart: got idx %0d nn %0d busy %0d want 0 1 1", o_index, o_new_note, o_busy); else npass++;
  endtask

  task automatic test_async_reset();
    repeat (4) note_pulse();
    ntotal++; if (o_index !== 4'd3) $display("FAIL areset_pre_index: got %0d want 3", o_index); else npass++;
    #2 i_rst = 1'b1;
    #1;
    ntotal++; if (o_busy !== 1'b0 || o_index !== 4'd0 || o_new_note !== 1'b0 || o_done !== 1'b0) $display("FAIL areset_regs: got busy %0d idx %0d nn %0d done %0d want 0 0 0 0", o_busy, o_index, o_new_note, o_done); else npass++;
    ntotal++; if (o_note !== NOTE_RST || o_envelope !== 9'd0 || o_phase_delta !== 32'd0) $display("FAIL areset_outs: got note %0d env %0d pd %0d want 0 0 0", o_note, o_envelope, o_phase_delta); else npass++;
    step();
    i_rst = 1'b0;
    step();
    start_play();
    ntotal++; if (o_note !== NOTE_C4 || o_index !== 4'd0 || o_busy !== 1'b1) $display("FAIL areset_replay: got note %0d idx %0d busy %0d want %0d 0 1", o_note, o_index, o_busy, NOTE_C4); else npass++;
  endtask

  task automatic test_live_write();
    wr(4'd0, NOTE_RST, 5'd0);
    ntotal++; if (o_note !== NOTE_RST || o_phase_delta !== 32'd0) $display("FAIL live_rest_note: got note %0d pd %0d want 0 0", o_note, o_phase_delta); else npass++;
    ntotal++; if (o_envelope !== 9'd0) $display("FAIL live_rest_env: got %0d want 0", o_envelope); else npass++;
    wr(4'd0, NOTE_A4, 5'd0);
    ntotal++; if (o_note !== NOTE_A4 || o_phase_delta !== PD_A4) $display("FAIL live_a4: got note %0d pd %0d want %0d %0d", o_note, o_phase_delta, NOTE_A4, PD_A4); else npass++;
    ntotal++; if (o_envelope !== 9'd14) $display("FAIL live_env: got %0d want 14", o_envelope); else npass++;
    stop_play();
  endtask

  initial begin
    i_rst = 1'b1; i_tick_stb = 1'b0; i_note_stb = 1'b0; i_start = 1'b0; i_stop = 1'b0;
    i_loop = 1'b0; i_last = 4'd0; i_wr_en = 1'b0; i_wr_addr = 4'd0; i_wr_note = 6'd0;
    i_wr_len = 5'd0; i_env_level = 9'd14; i_env_hold = 4'd2; i_env_decay = 9'd5;
    test_reset();
    test_oneshot();
    test_loop();
    test_envelope();
    test_stop_start();
    test_restart();
    test_async_reset();
    test_live_write();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
